serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor built around a single full-subtractor cell and a borrow flop.
- Computes diff = a - b - bin, LSB first, one bit per clock.
- Uses a start/busy/done handshake.
- Companion to the combinational full adder: the subtract direction of the same arithmetic datapath, trading area for WIDTH cycles of latency.

---
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin, LSB first) built on a single full-subtractor cell.
// Latency: start accepted at edge E0; done pulses in the cycle after edge E0+WIDTH; next accept at E0+WIDTH+2 or later.
// Backpressure: start is sampled only in IDLE and ignored while busy or done; diff/bout hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             br;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    logic             x;
    logic             y;
    logic             d;
    logic             borrow;
    logic [WIDTH-1:0] sr_next;
    logic             last;

    // Full-subtractor cell on the current LSBs plus the running borrow.
    assign x       = ra[0];
    assign y       = rb[0];
    assign d       = x ^ y ^ br;
    assign borrow  = (~x & y) | (~(x ^ y) & br);
    assign sr_next = {d, sr[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    // State register; reset drops straight to IDLE so busy/done fall at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; busy and done come purely from the state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, one bit of subtraction per SHIFT edge, result latch on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            br   <= 1'b0;
            sr   <= '0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        br  <= bin;
                        sr  <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    br  <= borrow;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff <= sr_next;
                        bout <= borrow;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8.
// Directed vector table plus hand-written sequences for ignored start, mid-op reset, reset in DONE and a held-start sweep.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same offset.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int n_checks;
    int n_fail;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; returns shift latency and number of busy cycles seen.
    // Leaves the bench sampling in the DONE cycle (or at the bound if done never came).
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                         output int lat, output int busy_cnt);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h3C;
        bin   = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
    endtask

    vec_t vecs[7];
    int   lat;
    int   bc;
    int   pulses;
    int   last_done_cyc;
    int   cyc;
    logic [8:0] e9;
    logic [7:0] ra_v;
    logic [7:0] rb_v;
    logic       rbin_v;

    always @(posedge clk) cyc++;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1};

        // Reset values
        step();
        step();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_diff", int'(diff), 0);
        check("reset_bout", int'(bout), 0);
        #2;
        rst_n = 1'b1;
        step();

        // Directed vector table
        foreach (vecs[i]) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, lat, bc);
            check($sformatf("vec%0d_latency", i), lat, WIDTH);
            check($sformatf("vec%0d_busy_cycles", i), bc, WIDTH);
            check($sformatf("vec%0d_done", i), int'(done), 1);
            check($sformatf("vec%0d_busy_in_done", i), int'(busy), 0);
            check($sformatf("vec%0d_diff", i), int'(diff), int'(vecs[i].exp_diff));
            check($sformatf("vec%0d_bout", i), int'(bout), int'(vecs[i].exp_bout));
            step();
            check($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
            check($sformatf("vec%0d_diff_held", i), int'(diff), int'(vecs[i].exp_diff));
        end

        // Second start during SHIFT is ignored
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        a = 8'h01; b = 8'h02; start = 1'b1;
        step();
        start  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            if (done) begin
                pulses++;
                check("hold_diff_at_done", int'(diff), 8'h1E);
                check("hold_bout_at_done", int'(bout), 0);
            end
            step();
        end
        check("hold_done_pulses", pulses, 1);
        for (int k = 0; k < 4; k++) begin
            check("hold_idle_diff", int'(diff), 8'h1E);
            check("hold_idle_bout", int'(bout), 0);
            check("hold_idle_busy", int'(busy), 0);
            step();
        end

        // Reset in the middle of SHIFT
        a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        check("midrst_busy_before", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_bout", int'(bout), 0);
        step();
        #2;
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (done || busy) pulses++;
        end
        check("midrst_no_activity", pulses, 0);
        do_op(8'h03, 8'h05, 1'b0, lat, bc);
        check("postrst_latency", lat, WIDTH);
        check("postrst_diff", int'(diff), 8'hFE);
        check("postrst_bout", int'(bout), 1);
        step();

        // Reset while done is high drops done immediately
        do_op(8'h20, 8'h01, 1'b0, lat, bc);
        check("donerst_done_before", int'(done), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("donerst_done", int'(done), 0);
        check("donerst_diff", int'(diff), 0);
        step();
        #2;
        rst_n = 1'b1;
        step();

        // Held-start random sweep: each op takes the operands present at its accept edge
        start         = 1'b1;
        last_done_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            ra_v   = 8'($urandom_range(0, 255));
            rb_v   = 8'($urandom_range(0, 255));
            rbin_v = 1'($urandom_range(0, 1));
            a   = ra_v;
            b   = rb_v;
            bin = rbin_v;
            step();
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            bin = 1'($urandom_range(0, 1));
            lat = 0;
            while (!done && lat < 40) begin
                step();
                lat++;
            end
            e9 = {1'b0, ra_v} - {1'b0, rb_v} - {8'd0, rbin_v};
            check($sformatf("rnd%0d_latency", k), lat, WIDTH);
            check($sformatf("rnd%0d_diff", k), int'(diff), int'(e9[7:0]));
            check($sformatf("rnd%0d_bout", k), int'(bout), int'(e9[8]));
            if (last_done_cyc >= 0)
                check($sformatf("rnd%0d_spacing", k), cyc - last_done_cyc, WIDTH + 2);
            last_done_cyc = cyc;
            step();
        end
        start = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
